// File: rtl/zxuno_regport_initiator.sv
// Z80-side initiator for the ZX-Uno register bus: decodes the address/data
// I/O ports, latches the selected register and strobes the responders.
module zxuno_regport_initiator #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regrd_stb,
  output logic        zxuno_regwr,
  output logic [7:0]  zxuno_wdata,
  input  logic [7:0]  regs_dout,
  input  logic        regs_oe_n
);

  typedef enum logic [1:0] {IDLE, RD_ACTIVE, WAIT_END} state_e;

  state_e     state_q;
  logic [1:0] iorq_sync_q, rd_sync_q, wr_sync_q;
  logic [7:0] addr_q, wdata_q;
  logic       regwr_q, regrd_stb_q;
  logic       io_rd, io_wr;
  logic       hit_addr, hit_data, rd_raw;

  // Strobes reset to their inactive level so no phantom cycle appears on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sync_q <= 2'b11;
      rd_sync_q   <= 2'b11;
      wr_sync_q   <= 2'b11;
    end else begin
      iorq_sync_q <= {iorq_sync_q[0], iorq_n};
      rd_sync_q   <= {rd_sync_q[0], rd_n};
      wr_sync_q   <= {wr_sync_q[0], wr_n};
    end
  end

  assign io_rd    = !iorq_sync_q[1] && !rd_sync_q[1];
  assign io_wr    = !iorq_sync_q[1] && !wr_sync_q[1];
  assign hit_addr = (a == ADDR_PORT);
  assign hit_data = (a == DATA_PORT);

  // Write is checked first so a (non-Z80) simultaneous rd/wr never raises a read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      regwr_q     <= 1'b0;
      regrd_stb_q <= 1'b0;
    end else begin
      regwr_q     <= 1'b0;
      regrd_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io_wr && hit_addr) begin
            addr_q  <= din;
            state_q <= WAIT_END;
          end else if (io_wr && hit_data) begin
            wdata_q <= din;
            regwr_q <= 1'b1;
            state_q <= WAIT_END;
          end else if (io_rd && hit_data) begin
            regrd_stb_q <= 1'b1;
            state_q     <= RD_ACTIVE;
          end else if (io_rd && hit_addr) begin
            state_q <= RD_ACTIVE;
          end
        end
        RD_ACTIVE: begin
          if (!io_rd) state_q <= IDLE;
        end
        WAIT_END: begin
          if (!io_rd && !io_wr) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read side uses the raw strobes so data reaches the CPU within the same cycle.
  assign rd_raw = !iorq_n && !rd_n;

  always_comb begin
    oe_n = 1'b1;
    dout = 8'hFF;
    if (rd_raw && hit_addr) begin
      oe_n = 1'b0;
      dout = addr_q;
    end else if (rd_raw && hit_data) begin
      oe_n = 1'b0;
      dout = regs_oe_n ? 8'hFF : regs_dout;
    end
  end

  assign zxuno_regrd     = rd_raw && hit_data;
  assign zxuno_addr      = addr_q;
  assign zxuno_wdata     = wdata_q;
  assign zxuno_regwr     = regwr_q;
  assign zxuno_regrd_stb = regrd_stb_q;

endmodule

// File: doc/zxuno_regport_initiator.md
Name: zxuno_regport_initiator

Overview:
- Z80-side front end of the ZX-Uno internal register bus.
- Decodes CPU I/O cycles on the address port (default FC3Bh) and the data port (default FD3Bh).
- Holds the selected register number and drives zxuno_addr, zxuno_regrd and zxuno_regwr towards all register responders.
- Returns responder read data, or the address register itself, onto the CPU data bus.

Parameters:
- ADDR_PORT, 16'hFC3B, full 16-bit I/O address of the register-select port.
- DATA_PORT, 16'hFD3B, full 16-bit I/O address of the register data port.

Ports:
- clk  input  1  system clock; at least 4x the CPU clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  16  CPU address bus.
- iorq_n  input  1  CPU IORQ, active low.
- rd_n  input  1  CPU RD, active low.
- wr_n  input  1  CPU WR, active low.
- din  input  8  CPU data bus, write direction.
- dout  output  8  data to CPU.
- oe_n  output  1  low when dout must drive the CPU bus.
- zxuno_addr  output  8  currently selected register number.
- zxuno_regrd  output  1  level; high while a data-port read cycle is active.
- zxuno_regrd_stb  output  1  one-clk pulse per data-port read, for read-side-effect registers.
- zxuno_regwr  output  1  one-clk pulse per data-port write.
- zxuno_wdata  output  8  write data, valid while zxuno_regwr is high and held afterwards.
- regs_dout  input  8  OR-combined responder read data.
- regs_oe_n  input  1  low when some responder claims the current address.

Behaviour:
- Reset (asynchronous, rst_n low): zxuno_addr=00h, zxuno_wdata=00h, zxuno_regrd=0, zxuno_regrd_stb=0, zxuno_regwr=0, state=IDLE. Outputs settle immediately, without waiting for a clock edge.
- Synchroniser: iorq_n, rd_n and wr_n pass through a 2-flop synchroniser into the clk domain. a and din are sampled only when a qualified cycle is detected; they are stable by then.
- Qualified cycles (decoded on synchronised strobes):
  - io_rd = !iorq_n_s & !rd_n_s.
  - io_wr = !iorq_n_s & !wr_n_s.
  - Port match uses a full 16-bit compare. Any other address is ignored.
- FSM state IDLE:
  - io_wr & a==ADDR_PORT -> zxuno_addr<=din; go to WAIT_END.
  - io_wr & a==DATA_PORT -> zxuno_wdata<=din; zxuno_regwr<=1 for exactly one clk; go to WAIT_END.
  - io_rd & a==DATA_PORT -> zxuno_regrd_stb<=1 for exactly one clk; go to RD_ACTIVE.
  - io_rd & a==ADDR_PORT -> go to RD_ACTIVE (address readback, no strobe).
- FSM state RD_ACTIVE:
  - Stay while io_rd holds; go to IDLE when io_rd deasserts.
- FSM state WAIT_END:
  - Stay until both io_rd and io_wr are false, then go to IDLE.
  - Guarantees exactly one strobe per CPU cycle, regardless of cycle length or wait states.
- Write latency: zxuno_regwr is high on the 3rd rising clk edge after the WR/IORQ falling edge (2 sync + 1 register).
- zxuno_regrd is combinational:
  - zxuno_regrd = !iorq_n & !rd_n & (a==DATA_PORT), using the raw strobes.
  - The responder data is therefore available on the CPU bus within the same read cycle, with no synchroniser delay.
- Read path (combinational), priority top to bottom:
  - a==ADDR_PORT & read active -> oe_n=0, dout=zxuno_addr.
  - a==DATA_PORT & read active & !regs_oe_n -> oe_n=0, dout=regs_dout.
  - a==DATA_PORT & read active & regs_oe_n -> oe_n=0, dout=FFh (unclaimed register reads FFh).
  - Otherwise oe_n=1, dout=FFh.
- zxuno_addr updates only on address-port writes. There is no auto-increment.
- Simultaneous rd and wr (illegal on a Z80):
  - Write takes priority; no read strobe is generated.
- Reset during a cycle:
  - Strobes are cleared immediately and the FSM returns to IDLE.
  - If the CPU cycle is still active when reset releases, the FSM is in IDLE and will still register that cycle.
  - The cycle may therefore produce a strobe; this is accepted.
- Back-to-back OUTs to the data port with the same address produce one zxuno_regwr pulse each, provided the IORQ inactive gap is >=2 clk.

Test Plan:
- Reset release, then OUT FC3Bh,0Eh -> zxuno_addr=0Eh after 3 clk; zxuno_regwr stays 0 throughout.
- After selecting 0Eh, OUT FD3Bh,5Ah held for 12 clk -> exactly one zxuno_regwr pulse; zxuno_wdata=5Ah; zxuno_addr=0Eh.
- IN FD3Bh with regs_oe_n=0, regs_dout=A5h -> oe_n=0, dout=A5h while the read is active; zxuno_regrd high; one zxuno_regrd_stb pulse.
- IN FD3Bh with regs_oe_n=1 -> dout=FFh, oe_n=0. IN FC3Bh -> dout=0Eh, no zxuno_regrd_stb.
- OUT FC3Ch,33h and OUT 7FFDh,07h -> no strobes; zxuno_addr unchanged. IN FE3Bh -> oe_n=1.
- Assert rst_n low mid-way through OUT FD3Bh,11h, before the strobe -> zxuno_regwr=0, zxuno_addr=00h immediately, with no clock edge required.
